// File: rtl/register_file_sb.sv
// Parametrised register bank: two async read ports, one write port with full/half/release modes,
// and a per-register pending-write scoreboard. Optional write-to-read bypass via REGFILE_BYPASS_EN.
module register_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] data_rs,
  output logic [DATA_W-1:0] data_rt,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_rs,
  output logic              busy_rt,
  output logic              sb_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int H     = DATA_W / 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_d  [DEPTH];
  logic              sb_ovf_q, sb_ovf_d;
  logic [DEPTH-1:0]  inc, dec;
  logic [DATA_W-1:0] old_w, merged_w;
  logic [DATA_W-1:0] rd_rs, rd_rt;

  // Value the addressed register will hold after this edge (also the bypass value).
  always_comb begin
    old_w = regs_q[wr_addr];
    unique case (wr_mode)
      2'b00:   merged_w = wr_data;
      2'b01:   merged_w = {old_w[DATA_W-1:H], wr_data[H-1:0]};
      2'b10:   merged_w = {wr_data[H-1:0], old_w[H-1:0]};
      default: merged_w = old_w;
    endcase
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
    assign inc[gi] = rsv_en && (rsv_addr == ADDR_W'(gi));
    assign dec[gi] = wr_en  && (wr_addr  == ADDR_W'(gi));
  end

  always_comb begin
    sb_ovf_d = sb_ovf_q;
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      cnt_d[i]  = cnt_q[i];
      if (dec[i] && wr_mode != 2'b11) regs_d[i] = merged_w;
      // Saturate instead of wrapping so a stuck count never silently frees a register.
      if (inc[i] && !dec[i]) begin
        if (cnt_q[i] == CNT_MAX) sb_ovf_d = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) sb_ovf_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      sb_ovf_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_ovf_q <= sb_ovf_d;
    end
  end

  always_comb begin
    rd_rs = regs_q[rs];
    rd_rt = regs_q[rt];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_mode != 2'b11 && wr_addr == rs) rd_rs = merged_w;
    if (wr_en && wr_mode != 2'b11 && wr_addr == rt) rd_rt = merged_w;
`endif
    data_rs = rst ? '0 : rd_rs;
    data_rt = rst ? '0 : rd_rt;
    busy_rs = !rst && (cnt_q[rs] != '0);
    busy_rt = !rst && (cnt_q[rt] != '0);
    sb_ovf  = sb_ovf_q;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed table-driven bench for register_file_sb plus hand sequences for bypass and async reset.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_mode;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rs, rt;
  logic [31:0] data_rs, data_rt;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        busy_rs, busy_rt, sb_ovf;

  int n_vec = 0;
  int n_err = 0;

  register_file_sb dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
    .wr_data(wr_data), .rs(rs), .rt(rt), .data_rs(data_rs), .data_rt(data_rt),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_rs(busy_rs), .busy_rt(busy_rt),
    .sb_ovf(sb_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [1:0]  wr_mode;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_brs;
    logic        e_brt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ers, input logic [31:0] ert,
                         input logic ebrs, input logic ebrt, input logic eovf);
    chk({tag, " data_rs"}, data_rs, ers);
    chk({tag, " data_rt"}, data_rt, ert);
    chk({tag, " busy_rs"}, {31'd0, busy_rs}, {31'd0, ebrs});
    chk({tag, " busy_rt"}, {31'd0, busy_rt}, {31'd0, ebrt});
    chk({tag, " sb_ovf"},  {31'd0, sb_ovf},  {31'd0, eovf});
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  initial begin
    // wr_en mode addr data | rsv_en addr | rs rt | exp data_rs data_rt busy_rs busy_rt ovf
    vecs[0]  = '{1'b1, 2'b00, 4'd5, 32'h12345678, 1'b1, 4'd5, 4'd5, 4'd3, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'b01, 4'd5, 32'h0000ABCD, 1'b1, 4'd5, 4'd5, 4'd3, 32'h1234ABCD, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 4'd5, 32'h00001111, 1'b1, 4'd5, 4'd5, 4'd3, 32'h1111ABCD, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 4'd0, 32'h0,        1'b1, 4'd7, 4'd7, 4'd5, 32'h0, 32'h1111ABCD, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 4'd0, 32'h0,        1'b1, 4'd7, 4'd7, 4'd5, 32'h0, 32'h1111ABCD, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2'b00, 4'd7, 32'h12340000, 1'b0, 4'd0, 4'd7, 4'd5, 32'h12340000, 32'h1111ABCD, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'b00, 4'd7, 32'hCAFE0000, 1'b0, 4'd0, 4'd7, 4'd5, 32'hCAFE0000, 32'h1111ABCD, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 4'd0, 32'h0,        1'b1, 4'd9, 4'd9, 4'd7, 32'h0, 32'hCAFE0000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'b00, 4'd9, 32'h0BADF00D, 1'b1, 4'd9, 4'd9, 4'd7, 32'h0BADF00D, 32'hCAFE0000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 2'b11, 4'd9, 32'hFFFFFFFF, 1'b0, 4'd0, 4'd9, 4'd7, 32'h0BADF00D, 32'hCAFE0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 4'd0, 32'h0,        1'b0, 4'd0, 4'd9, 4'd9, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 2'b00, 4'd0, 32'hA5A5A5A5, 1'b1, 4'd0, 4'd0, 4'd9, 32'hA5A5A5A5, 32'h0BADF00D, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 4'd0, 32'h0,        1'b1, 4'd2, 4'd2, 4'd0, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 4'd0, 32'h0,        1'b1, 4'd2, 4'd2, 4'd0, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 4'd0, 32'h0,        1'b1, 4'd2, 4'd2, 4'd0, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 2'b00, 4'd0, 32'h0,        1'b1, 4'd2, 4'd2, 4'd0, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 2'b00, 4'd4, 32'h00000077, 1'b0, 4'd0, 4'd4, 4'd2, 32'h00000077, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 2'b11, 4'd2, 32'h0,        1'b0, 4'd0, 4'd2, 4'd4, 32'h0, 32'h00000077, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 2'b11, 4'd2, 32'h0,        1'b0, 4'd0, 4'd2, 4'd4, 32'h0, 32'h00000077, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 2'b11, 4'd2, 32'h0,        1'b0, 4'd0, 4'd2, 4'd4, 32'h0, 32'h00000077, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; idle(); wr_mode = 2'b00; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    rs = 4'd3; rt = 4'd15;
    #2;
    chk_all("reset_hold", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("reset_release", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_en = vecs[i].wr_en; wr_mode = vecs[i].wr_mode; wr_addr = vecs[i].wr_addr;
      wr_data = vecs[i].wr_data; rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
      rs = vecs[i].rs; rt = vecs[i].rt;
      @(posedge clk); #1;
      idle();
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_rs, vecs[i].e_rt, vecs[i].e_brs, vecs[i].e_brt, vecs[i].e_ovf);
      $display("vector %0d: rs=%0d data_rs=%h rt=%0d data_rt=%h busy=%b%b ovf=%b",
               i, rs, data_rs, rt, data_rt, busy_rs, busy_rt, sb_ovf);
    end

    // Bypass: pre-edge visibility of a half write depends on the build option.
    @(negedge clk);
    wr_en = 1'b1; wr_mode = 2'b00; wr_addr = 4'd6; wr_data = 32'hFFFF0000;
    rsv_en = 1'b1; rsv_addr = 4'd6; rs = 4'd6; rt = 4'd2;
    @(posedge clk); #1; idle(); #1;
    chk("byp_setup data_rs", data_rs, 32'hFFFF0000);
    @(negedge clk);
    wr_en = 1'b1; wr_mode = 2'b01; wr_addr = 4'd6; wr_data = 32'h00000042;
    rsv_en = 1'b1; rsv_addr = 4'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre data_rs", data_rs, 32'hFFFF0042);
`else
    chk("byp_pre data_rs", data_rs, 32'hFFFF0000);
`endif
    chk("byp_pre busy_rs", {31'd0, busy_rs}, 32'd0);
    @(posedge clk); #1; idle(); #1;
    chk("byp_post data_rs", data_rs, 32'hFFFF0042);
    $display("bypass: data_rs=%h", data_rs);

    // Async reset mid-cycle with a register busy and the error flag set.
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 4'd10; rs = 4'd10; rt = 4'd5;
    @(posedge clk); #1; idle(); #1;
    chk_all("pre_rst", 32'h0, 32'h1111ABCD, 1'b1, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 1'b1; wr_mode = 2'b00; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 4'd5;
    @(posedge clk); #1; idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("post_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    $display("reset: data_rt=%h busy_rs=%b ovf=%b", data_rt, busy_rs, sb_ovf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the 16x32 general-purpose register bank.
- Width and depth are parametrised; two asynchronous read ports and one write port.
- Write modes: full word, low-half load (LCL) and high-half load (LCH).
- Per-register pending-write scoreboard: decode uses it to stall on RAW hazards while producers are in flight in the pipeline.

Parameters:
- DATA_W, 32, register width in bits; must be even, >= 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- CNT_W, 2, width of each per-register pending counter; max in-flight producers per register = 2**CNT_W - 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write enable.
- wr_mode  in  2  00 full, 01 low half, 10 high half, 11 release.
- wr_addr  in  ADDR_W  write destination.
- wr_data  in  DATA_W  write data; low DATA_W/2 bits are used in modes 01/10.
- rs  in  ADDR_W  read port A address.
- rt  in  ADDR_W  read port B address.
- data_rs  out  DATA_W  read port A data.
- data_rt  out  DATA_W  read port B data.
- rsv_en  in  1  reserve: an instruction writing rsv_addr has issued.
- rsv_addr  in  ADDR_W  register being reserved.
- busy_rs  out  1  rs has pending writes.
- busy_rt  out  1  rt has pending writes.
- sb_ovf  out  1  sticky scoreboard error flag.

Behaviour:
- Reset (async, active-high, immediate):
  - All DEPTH registers clear to 0.
  - All pending counters clear to 0; sb_ovf clears to 0.
  - Outputs while rst is high: data_rs = data_rt = 0, busy_rs = busy_rt = 0.
  - Reset mid-operation discards any same-edge write or reserve.
- Reads:
  - Combinational from the array; no latency.
  - rs == rt is legal; both ports return the same value.
- Write (rising edge, wr_en = 1, H = DATA_W/2):
  - 00: reg <= wr_data.
  - 01: reg[H-1:0] <= wr_data[H-1:0]; upper half unchanged.
  - 10: reg[DATA_W-1:H] <= wr_data[H-1:0]; lower half unchanged.
  - 11: register contents unchanged; scoreboard still decrements. Used for squashed producers.
- Scoreboard, per register i, at the clock edge:
  - inc = rsv_en && rsv_addr == i.
  - dec = wr_en && wr_addr == i.
  - inc && dec: count unchanged.
  - inc only: count + 1. If count is already at max, the count holds and sb_ovf sets.
  - dec only: count - 1. If count is already 0, the count holds and sb_ovf sets (write without reservation).
  - busy for a register = (count != 0), read combinationally for rs/rt.
  - busy reflects the registered count only. A reserve or write in the current cycle affects busy from the next cycle.
  - sb_ovf stays set until rst.
- No register is hardwired to zero; register 0 is writable like any other.
- Single write port only: simultaneous writes cannot occur.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When wr_en = 1, wr_mode != 11 and wr_addr == rs, data_rs shows the merged value that will be written at the next edge (new half plus the retained old half for modes 01/10).
  - Same rule for rt.
  - busy outputs are unaffected.
- Undefined: reads always return the stored array value; the write becomes visible the cycle after the edge.

Test Plan:
- Reset then read: assert rst, release; read rs = 3, rt = 15 -> data_rs = data_rt = 0, busy_rs = busy_rt = 0, sb_ovf = 0.
- Half writes:
  - Full write reg 5 = 32'h12345678.
  - Mode 01 with wr_data = 32'h0000ABCD -> reg 5 = 32'h1234ABCD.
  - Mode 10 with 32'h00001111 -> reg 5 = 32'h1111ABCD.
- Scoreboard:
  - Reserve reg 7 twice -> busy_rs (rs = 7) = 1 with count 2.
  - One write -> still busy.
  - Second write (data 32'hCAFE0000) -> busy_rs = 0, data_rs = 32'hCAFE0000.
- Simultaneous events:
  - Reserve and write reg 9 in the same cycle with count 1 -> count stays 1, busy stays 1.
  - Release (mode 11) -> busy 0, data unchanged.
- Error flag:
  - Reserve reg 2 four times (CNT_W = 2) -> count stays 3, sb_ovf = 1.
  - Write reg 4 with count 0 -> sb_ovf stays 1, count stays 0.
  - Async rst mid-cycle -> sb_ovf = 0 immediately.
- Bypass:
  - With REGFILE_BYPASS_EN defined: reg 6 = 32'hFFFF0000; drive mode 01, 32'h00000042, wr_addr = rs = 6 -> data_rs = 32'hFFFF0042 before the edge.
  - Without the macro: data_rs = 32'hFFFF0000 until after the edge.
